// File: rtl/fsm_pkg.sv
// Shared definitions for the serial pattern-detector FSMs: state width helper and overlap mode encodings.
package fsm_pkg;

    // Width needed to hold a matched-prefix length in 0..pat_w.
    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam logic MODE_NON_OVERLAP = 1'b0;
    localparam logic MODE_OVERLAP     = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_seq_detect.sv
// Serial pattern detector: state is the matched prefix length, with KMP-style fallback,
// Moore and Mealy match flags, selectable overlap and a saturating match counter.
module fsm_seq_detect
    import fsm_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    localparam int              SW      = state_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             overlap,
    input  logic             clr,
    output logic             match_mealy,
    output logic             match_moore,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    prefix_len
);

    // Handshake: din is consumed only on a rising edge where en=1; en=0 freezes state and counter.

    localparam logic [SW-1:0] FULL = SW'(PAT_W);

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;
    logic [SW-1:0] trans_from;
    logic [SW-1:0] fallback_len;

    function automatic logic pat_bit(input int idx);
        logic [PAT_W-1:0] sh;
        sh = PATTERN >> idx;
        return sh[0];
    endfunction

    // Longest suffix of (prefix_k, d) that is also a prefix of PATTERN; all lengths checked, longest wins.
    function automatic logic [SW-1:0] fallback(input logic [SW-1:0] k, input logic d);
        int            kk;
        logic          ok;
        logic [SW-1:0] best;
        kk   = int'(k);
        if (kk > PAT_W) kk = 0;
        best = '0;
        for (int l = 1; l <= PAT_W; l++) begin
            if (l <= kk + 1) begin
                ok = (d == pat_bit(PAT_W - l));
                for (int j = 0; j < PAT_W - 1; j++) begin
                    if ((j < l - 1) && (pat_bit(PAT_W - 1 - (kk - l + 1 + j)) != pat_bit(PAT_W - 1 - j))) begin
                        ok = 1'b0;
                    end
                end
                if (ok) best = SW'(l);
            end
        end
        return best;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a completed match restarts from empty when overlap is off.
    always_comb begin
        trans_from = state;
        if ((state == FULL) && (overlap != MODE_OVERLAP)) begin
            trans_from = '0;
        end
        fallback_len = fallback(trans_from, din);
        state_nxt    = state;
        if (clr) begin
            state_nxt = '0;
        end else if (en) begin
            state_nxt = fallback_len;
        end
    end

    // Output logic
    always_comb begin
        match_mealy = en & (fallback_len == FULL) & ~clr;
        match_moore = (state == FULL);
        prefix_len  = state;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .inc  (match_mealy),
        .q    (match_cnt)
    );

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Self-checking bench for fsm_seq_detect: directed scenarios plus randomized traffic against a
// history-string reference model; a second instance with a 2-bit counter covers saturation.
module tb_fsm_seq_detect;
    import fsm_pkg::*;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         CNT_W   = 8;
    localparam int         SAT_W   = 2;
    localparam int         SW      = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             en, din, overlap, clr;
    logic             match_mealy, match_moore;
    logic [CNT_W-1:0] match_cnt;
    logic [SW-1:0]    prefix_len;
    logic             match_mealy_s, match_moore_s;
    logic [SAT_W-1:0] match_cnt_s;
    logic [SW-1:0]    prefix_len_s;

    fsm_seq_detect #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clr(clr),
        .match_mealy(match_mealy), .match_moore(match_moore),
        .match_cnt(match_cnt), .prefix_len(prefix_len)
    );

    fsm_seq_detect #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap), .clr(clr),
        .match_mealy(match_mealy_s), .match_moore(match_moore_s),
        .match_cnt(match_cnt_s), .prefix_len(prefix_len_s)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [3:0] pat = PATTERN;
    bit         hist[$];
    int         m_state;
    int         m_cnt;
    int         m_cnt_s;
    logic       obs_mealy, obs_mealy_s;
    logic [CNT_W-1:0] exp_q[$];

    function automatic int longest_match();
        int best = 0;
        for (int l = 1; l <= PAT_W; l++) begin
            if (l <= hist.size()) begin
                bit ok = 1'b1;
                for (int i = 0; i < l; i++)
                    if (hist[hist.size() - l + i] != pat[PAT_W-1-i]) ok = 1'b0;
                if (ok) best = l;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_state = 0;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic model_step(input logic e, input logic d, input logic o, input logic c,
                              output logic exp_mealy);
        exp_mealy = 1'b0;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (m_state == PAT_W && o == MODE_NON_OVERLAP) hist.delete();
            hist.push_back(d);
            if (hist.size() > PAT_W) void'(hist.pop_front());
            m_state = longest_match();
            if (m_state == PAT_W) begin
                exp_mealy = 1'b1;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (m_cnt_s < (1 << SAT_W) - 1) m_cnt_s++;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic d, input logic o, input logic c);
        @(negedge clk);
        en = e; din = d; overlap = o; clr = c;
        #1;
        obs_mealy   = match_mealy;
        obs_mealy_s = match_mealy_s;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        logic em;
        model_step(1'b0, 1'b0, 1'b1, 1'b1, em);
        step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++;
        if (prefix_len !== 3'd0 || match_moore !== 1'b0 || match_cnt !== 8'd0 || match_mealy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got len=%0d moore=%b cnt=%0d mealy=%b expected all 0",
                     prefix_len, match_moore, match_cnt, match_mealy);
        end
        n_tests++;
        if (prefix_len_s !== 3'd0 || match_cnt_s !== 2'd0 || match_moore_s !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_sat: got len=%0d cnt=%0d moore=%b expected all 0",
                     prefix_len_s, match_cnt_s, match_moore_s);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1011011;
        logic em;
        clear_all();
        for (int i = 0; i < 7; i++) begin
            model_step(1'b1, s[6-i], 1'b1, 1'b0, em);
            step(1'b1, s[6-i], 1'b1, 1'b0);
            n_tests++;
            if (obs_mealy !== ((i == 3) || (i == 6)) || obs_mealy !== em) begin
                n_fail++;
                $display("FAIL overlap_mealy bit %0d: got %b expected %b", i + 1, obs_mealy, em);
            end
            n_tests++;
            if (match_moore !== (m_state == PAT_W) || prefix_len !== SW'(m_state)) begin
                n_fail++;
                $display("FAIL overlap_state bit %0d: got moore=%b len=%0d expected moore=%b len=%0d",
                         i + 1, match_moore, prefix_len, (m_state == PAT_W), m_state);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_cnt: got %0d expected 2", match_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] s = 7'b1011011;
        logic em;
        clear_all();
        for (int i = 0; i < 7; i++) begin
            model_step(1'b1, s[6-i], 1'b0, 1'b0, em);
            step(1'b1, s[6-i], 1'b0, 1'b0);
            n_tests++;
            if (obs_mealy !== (i == 3) || obs_mealy !== em) begin
                n_fail++;
                $display("FAIL nonoverlap_mealy bit %0d: got %b expected %b", i + 1, obs_mealy, em);
            end
        end
        n_tests++;
        if (prefix_len !== 3'd1 || match_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL nonoverlap_end: got len=%0d cnt=%0d expected len=1 cnt=1", prefix_len, match_cnt);
        end
    endtask

    task automatic test_enable_gap();
        logic em;
        clear_all();
        for (int i = 0; i < 3; i++) begin
            model_step(1'b1, (i != 1), 1'b1, 1'b0, em);
            step(1'b1, (i != 1), 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            model_step(1'b0, i[0], 1'b1, 1'b0, em);
            step(1'b0, i[0], 1'b1, 1'b0);
            n_tests++;
            if (prefix_len !== 3'd3 || obs_mealy !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_hold cycle %0d: got len=%0d mealy=%b expected len=3 mealy=0",
                         i, prefix_len, obs_mealy);
            end
        end
        model_step(1'b1, 1'b1, 1'b1, 1'b0, em);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (obs_mealy !== 1'b1 || match_cnt !== 8'd1 || match_moore !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_match: got mealy=%b cnt=%0d moore=%b expected 1/1/1",
                     obs_mealy, match_cnt, match_moore);
        end
        // Moore must hold in the match state while en is low.
        for (int i = 0; i < 2; i++) begin
            model_step(1'b0, 1'b1, 1'b1, 1'b0, em);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if (match_moore !== 1'b1 || obs_mealy !== 1'b0 || match_cnt !== 8'd1) begin
                n_fail++;
                $display("FAIL gap_moore_hold cycle %0d: got moore=%b mealy=%b cnt=%0d expected 1/0/1",
                         i, match_moore, obs_mealy, match_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] s = 4'b1011;
        logic [SAT_W-1:0] exp_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic em;
        clear_all();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                model_step(1'b1, s[3-i], 1'b1, 1'b0, em);
                step(1'b1, s[3-i], 1'b1, 1'b0);
            end
            n_tests++;
            if (match_cnt_s !== exp_sat[r] || match_cnt_s !== SAT_W'(m_cnt_s)) begin
                n_fail++;
                $display("FAIL saturation rep %0d: got %0d expected %0d", r + 1, match_cnt_s, exp_sat[r]);
            end
        end
        n_tests++;
        if (match_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL saturation_wide: got %0d expected 5", match_cnt);
        end
    endtask

    task automatic test_clr_collision();
        logic em;
        clear_all();
        for (int i = 0; i < 3; i++) begin
            model_step(1'b1, (i != 1), 1'b1, 1'b0, em);
            step(1'b1, (i != 1), 1'b1, 1'b0);
        end
        model_step(1'b1, 1'b1, 1'b1, 1'b1, em);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs_mealy !== 1'b0 || match_cnt !== 8'd0 || prefix_len !== 3'd0 || match_moore !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_collision: got mealy=%b cnt=%0d len=%0d moore=%b expected all 0",
                     obs_mealy, match_cnt, prefix_len, match_moore);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] s = 4'b1011;
        logic em;
        clear_all();
        for (int n = 0; n < 23; n++) begin
            model_step(1'b1, s[3 - (n % 4)], 1'b1, 1'b0, em);
            step(1'b1, s[3 - (n % 4)], 1'b1, 1'b0);
        end
        n_tests++;
        if (prefix_len !== 3'd3 || match_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL async_setup: got len=%0d cnt=%0d expected len=3 cnt=5", prefix_len, match_cnt);
        end
        #2;
        reset = 1'b0;
        en    = 1'b0;
        #1;
        n_tests++;
        if (prefix_len !== 3'd0 || match_cnt !== 8'd0 || match_moore !== 1'b0 || match_cnt_s !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got len=%0d cnt=%0d moore=%b cnt_s=%0d expected all 0",
                     prefix_len, match_cnt, match_moore, match_cnt_s);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model_step(1'b1, s[3-i], 1'b1, 1'b0, em);
            step(1'b1, s[3-i], 1'b1, 1'b0);
        end
        n_tests++;
        if (match_cnt !== 8'd1 || match_moore !== 1'b1) begin
            n_fail++;
            $display("FAIL async_after: got cnt=%0d moore=%b expected cnt=1 moore=1", match_cnt, match_moore);
        end
    endtask

    task automatic test_random();
        logic em;
        logic e, d, o, c;
        logic [CNT_W-1:0] exp_cnt;
        clear_all();
        o = 1'b1;
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 9) < 8);
            d = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 19) == 0) o = ~o;
            c = ($urandom_range(0, 49) == 0);
            model_step(e, d, o, c, em);
            exp_q.push_back(CNT_W'(m_cnt));
            step(e, d, o, c);
            exp_cnt = exp_q.pop_front();
            n_tests++;
            if (obs_mealy !== em || prefix_len !== SW'(m_state) || match_moore !== (m_state == PAT_W)) begin
                n_fail++;
                $display("FAIL random_state step %0d: got mealy=%b len=%0d moore=%b expected mealy=%b len=%0d",
                         n, obs_mealy, prefix_len, match_moore, em, m_state);
            end
            n_tests++;
            if (match_cnt !== exp_cnt || match_cnt_s !== SAT_W'(m_cnt_s)) begin
                n_fail++;
                $display("FAIL random_cnt step %0d: got cnt=%0d cnt_s=%0d expected cnt=%0d cnt_s=%0d",
                         n, match_cnt, match_cnt_s, exp_cnt, m_cnt_s);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b1; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_overlap();
        test_non_overlap();
        test_enable_gap();
        test_saturation();
        test_clr_collision();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
